// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer
// Control sequencer for the systolic matrix-multiply kernel.
//
// A start pulse walks every N1 x N2 output tile of an M x M product, with tb
// as the inner loop and ta as the outer loop. Each tile streams the M-deep K
// dimension from the A/B operand buffers and then waits out the array skew.
// The finished tile is offered to the result path with a valid/ready
// handshake. A one-cycle done pulse follows acceptance of the last tile.
//
// Optional feature macro: MM_SEQ_PERF_CNT_EN
//   defined   -> perf_cycles counts busy cycles (excluding DONE), saturating
//   undefined -> perf_cycles is tied to zero and no counter is built
//
// Reset: asynchronous, active-low, on port rst.

module mm_tile_sequencer #(
  parameter int N1 = 4,
  parameter int N2 = 4,
  parameter int M  = 8
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               start,
  input  logic                                               abort,
  input  logic                                               stall,
  input  logic                                               res_ready,
  output logic                                               busy,
  output logic                                               rd_en,
  output logic [$clog2(M*M/N1)-1:0]                          rd_addr_A,
  output logic [$clog2(M*M/N2)-1:0]                          rd_addr_B,
  output logic                                               acc_clr,
  output logic                                               res_valid,
  output logic [((M/N1) > 1 ? $clog2(M/N1) : 1)-1:0]         res_tile_row,
  output logic [((M/N2) > 1 ? $clog2(M/N2) : 1)-1:0]         res_tile_col,
  output logic                                               done,
  output logic [31:0]                                        perf_cycles
);

  // Derived widths for counters and addresses
  localparam int AW_A = $clog2(M*M/N1);
  localparam int AW_B = $clog2(M*M/N2);
  localparam int TRW  = (M/N1) > 1 ? $clog2(M/N1) : 1;
  localparam int TCW  = (M/N2) > 1 ? $clog2(M/N2) : 1;
  localparam int KW   = M > 1 ? $clog2(M) : 1;
  localparam int DW   = $clog2(N1 + N2);

  // Terminal values for each counter
  localparam logic [KW-1:0]  K_LAST     = KW'(M - 1);
  localparam logic [TRW-1:0] TA_LAST    = TRW'(M/N1 - 1);
  localparam logic [TCW-1:0] TB_LAST    = TCW'(M/N2 - 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(N1 + N2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_DRAIN  = 3'd2,
    S_RESULT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [TRW-1:0] ta_q, ta_d;
  logic [TCW-1:0] tb_q, tb_d;
  logic [DW-1:0]  drain_q, drain_d;

  // Next-state and counter update; abort overrides every transition
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ta_d    = ta_q;
    tb_d    = tb_q;
    drain_d = drain_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = '0;
          ta_d    = '0;
          tb_d    = '0;
          drain_d = '0;
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (!stall) begin
          if (k_q == K_LAST) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_RESULT;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end

      S_RESULT: begin
        if (res_ready) begin
          if ((ta_q == TA_LAST) && (tb_q == TB_LAST)) begin
            state_d = S_DONE;
          end else begin
            k_d = '0;
            if (tb_q == TB_LAST) begin
              tb_d = '0;
              ta_d = ta_q + TRW'(1);
            end else begin
              tb_d = tb_q + TCW'(1);
            end
            state_d = S_STREAM;
          end
        end
      end

      S_DONE: begin
        k_d     = '0;
        ta_d    = '0;
        tb_d    = '0;
        drain_d = '0;
        state_d = S_IDLE;
      end

      default: begin
        k_d     = '0;
        ta_d    = '0;
        tb_d    = '0;
        drain_d = '0;
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      k_d     = '0;
      ta_d    = '0;
      tb_d    = '0;
      drain_d = '0;
      state_d = S_IDLE;
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      ta_q    <= '0;
      tb_q    <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      drain_q <= drain_d;
    end
  end

  // Output decode; only rd_en/acc_clr see an input (stall) combinationally
  always_comb begin
    busy         = (state_q != S_IDLE);
    rd_en        = (state_q == S_STREAM) && !stall;
    acc_clr      = (state_q == S_STREAM) && (k_q == '0) && !stall;
    res_valid    = (state_q == S_RESULT);
    done         = (state_q == S_DONE);
    res_tile_row = ta_q;
    res_tile_col = tb_q;
    rd_addr_A    = AW_A'(ta_q) * AW_A'(M) + AW_A'(k_q);
    rd_addr_B    = AW_B'(tb_q) * AW_B'(M) + AW_B'(k_q);
  end

`ifdef MM_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;
  logic        perf_count;

  // Busy-cycle counter: clears on an accepted start, saturates at all-ones
  always_comb begin
    perf_d     = perf_q;
    perf_count = (state_q == S_STREAM) || (state_q == S_DRAIN) ||
                 (state_q == S_RESULT);
    if ((state_q == S_IDLE) && start && !abort) begin
      perf_d = '0;
    end else if (perf_count && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Performance counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// tb_mm_tile_sequencer
// Directed bench for mm_tile_sequencer (M=8, N1=N2=4). Stimulus pushes the
// expected tile results and done cycles into queues; a negedge monitor pops
// and compares them whenever the DUT completes a handshake or pulses done.
// Cycle numbers are relative to the cycle in which start is sampled in IDLE.

module tb_mm_tile_sequencer;

  localparam int N1 = 4;
  localparam int N2 = 4;
  localparam int M  = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        stall;
  logic        res_ready;
  logic        busy;
  logic        rd_en;
  logic [3:0]  rd_addr_A;
  logic [3:0]  rd_addr_B;
  logic        acc_clr;
  logic        res_valid;
  logic [0:0]  res_tile_row;
  logic [0:0]  res_tile_col;
  logic        done;
  logic [31:0] perf_cycles;

  typedef struct {
    int row;
    int col;
    int cyc;
  } exp_res_t;

  exp_res_t res_q[$];
  int       done_q[$];

  int cyc;
  int base;
  int n_cmp;
  int n_fail;

  mm_tile_sequencer #(.N1(N1), .N2(N2), .M(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .stall        (stall),
    .res_ready    (res_ready),
    .busy         (busy),
    .rd_en        (rd_en),
    .rd_addr_A    (rd_addr_A),
    .rd_addr_B    (rd_addr_B),
    .acc_clr      (acc_clr),
    .res_valid    (res_valid),
    .res_tile_row (res_tile_row),
    .res_tile_col (res_tile_col),
    .done         (done),
    .perf_cycles  (perf_cycles)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute cycle counter used to time-stamp monitor events
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point; every check in the bench goes through here
  function automatic void check_output(input string name, input longint actual,
                                       input longint expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual,
               expected, cyc - base);
    end
  endfunction

  // Monitor: pops the scoreboard on every accepted result and every done
  always @(negedge clk) begin
    exp_res_t e;
    if (rst) begin
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) begin
          check_output("unexpected_result", 1, 0);
        end else begin
          e = res_q.pop_front();
          check_output("res_tile_row", res_tile_row, e.row);
          check_output("res_tile_col", res_tile_col, e.col);
          check_output("res_cycle", cyc - base, e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check_output("unexpected_done", 1, 0);
        end else begin
          check_output("done_cycle", cyc - base, done_q.pop_front());
        end
      end
    end
  end

  // Watchdog so the bench always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance until the given relative cycle, landing 1 time unit after the edge
  task automatic wait_cycle(input int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise start in the current cycle (cycle 0) and queue a full product
  task automatic apply_stimulus(input int t0, input int t1, input int t2,
                                input int t3, input int td);
    exp_res_t e;
    base  = cyc;
    start = 1'b1;
    e = '{row: 0, col: 0, cyc: t0}; res_q.push_back(e);
    e = '{row: 0, col: 1, cyc: t1}; res_q.push_back(e);
    e = '{row: 1, col: 0, cyc: t2}; res_q.push_back(e);
    e = '{row: 1, col: 1, cyc: t3}; res_q.push_back(e);
    done_q.push_back(td);
  endtask

  function automatic longint perf_expect(input longint v);
`ifdef MM_SEQ_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Directed scenarios
  initial begin
    exp_res_t e;
    n_cmp = 0; n_fail = 0; base = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0; res_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", busy, 0);
    check_output("rst_rd_en", rd_en, 0);
    check_output("rst_acc_clr", acc_clr, 0);
    check_output("rst_addr_A", rd_addr_A, 0);
    check_output("rst_addr_B", rd_addr_B, 0);
    check_output("rst_res_valid", res_valid, 0);
    check_output("rst_done", done, 0);
    check_output("rst_perf", perf_cycles, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: clean product, tiles every 17 cycles, done at 69
    $display("[TB] scenario 1: full product");
    apply_stimulus(17, 34, 51, 68, 69);
    wait_cycle(1);
    start = 1'b0;
    check_output("s1_rd_en_c1", rd_en, 1);
    check_output("s1_acc_clr_c1", acc_clr, 1);
    check_output("s1_busy", busy, 1);
    for (int k = 0; k < M; k++) begin
      wait_cycle(52 + k);
      check_output("s1_t3_rd_en", rd_en, 1);
      check_output("s1_t3_addr_A", rd_addr_A, 8 + k);
      check_output("s1_t3_addr_B", rd_addr_B, 8 + k);
      check_output("s1_t3_acc_clr", acc_clr, (k == 0) ? 1 : 0);
    end
    wait_cycle(60);
    check_output("s1_drain_rd_en", rd_en, 0);
    wait_cycle(70);
    check_output("s1_idle_busy", busy, 0);
    check_output("s1_perf", perf_cycles, perf_expect(68));

    // Scenario 2: 3-cycle stall at k=5; start held through DONE
    $display("[TB] scenario 2: stall in tile 0");
    wait_cycle(72);
    apply_stimulus(20, 37, 54, 71, 72);
    wait_cycle(1);
    start = 1'b0;
    wait_cycle(6);
    for (int s = 0; s < 3; s++) begin
      wait_cycle(6 + s);
      stall = 1'b1;
      #1;
      check_output("s2_stall_rd_en", rd_en, 0);
      check_output("s2_stall_acc_clr", acc_clr, 0);
      check_output("s2_stall_addr_A", rd_addr_A, 5);
      check_output("s2_stall_addr_B", rd_addr_B, 5);
    end
    wait_cycle(9);
    stall = 1'b0;
    #1;
    check_output("s2_resume_rd_en", rd_en, 1);
    check_output("s2_resume_addr_A", rd_addr_A, 5);
    wait_cycle(70);
    start = 1'b1;
    wait_cycle(73);
    start = 1'b0;
    check_output("s2_no_retrigger", busy, 0);
    check_output("s2_perf", perf_cycles, perf_expect(71));
    wait_cycle(74);
    check_output("s2_still_idle", busy, 0);

    // Scenario 3: result held for 4 cycles of res_ready low
    $display("[TB] scenario 3: backpressure on tile 0 result");
    apply_stimulus(21, 38, 55, 72, 73);
    wait_cycle(1);
    start = 1'b0;
    wait_cycle(16);
    res_ready = 1'b0;
    for (int c = 17; c <= 20; c++) begin
      wait_cycle(c);
      check_output("s3_hold_valid", res_valid, 1);
      check_output("s3_hold_row", res_tile_row, 0);
      check_output("s3_hold_col", res_tile_col, 0);
      check_output("s3_hold_rd_en", rd_en, 0);
    end
    wait_cycle(21);
    res_ready = 1'b1;
    wait_cycle(22);
    check_output("s3_t1_rd_en", rd_en, 1);
    check_output("s3_t1_acc_clr", acc_clr, 1);
    check_output("s3_t1_addr_A", rd_addr_A, 0);
    check_output("s3_t1_addr_B", rd_addr_B, 8);
    wait_cycle(75);
    check_output("s3_perf", perf_cycles, perf_expect(72));

    // Scenario 4: abort during tile-2 drain, then restart
    $display("[TB] scenario 4: abort in tile 2 drain");
    base  = cyc;
    start = 1'b1;
    e = '{row: 0, col: 0, cyc: 17}; res_q.push_back(e);
    e = '{row: 0, col: 1, cyc: 34}; res_q.push_back(e);
    wait_cycle(1);
    start = 1'b0;
    wait_cycle(45);
    abort = 1'b1;
    wait_cycle(46);
    abort = 1'b0;
    check_output("s4_abort_busy", busy, 0);
    check_output("s4_abort_res_valid", res_valid, 0);
    check_output("s4_abort_addr_A", rd_addr_A, 0);
    wait_cycle(52);
    check_output("s4_post_abort_idle", busy, 0);
    base  = cyc;
    start = 1'b1;
    wait_cycle(1);
    start = 1'b0;
    check_output("s4_restart_rd_en", rd_en, 1);
    check_output("s4_restart_acc_clr", acc_clr, 1);
    check_output("s4_restart_addr_A", rd_addr_A, 0);
    check_output("s4_restart_addr_B", rd_addr_B, 0);

    // Scenario 5: asynchronous reset mid-stream, start held through reset
    $display("[TB] scenario 5: reset mid-stream");
    wait_cycle(5);
    check_output("s5_pre_addr_A", rd_addr_A, 4);
    rst   = 1'b0;
    start = 1'b1;
    #1;
    check_output("s5_rst_busy", busy, 0);
    check_output("s5_rst_rd_en", rd_en, 0);
    check_output("s5_rst_acc_clr", acc_clr, 0);
    check_output("s5_rst_addr_A", rd_addr_A, 0);
    check_output("s5_rst_addr_B", rd_addr_B, 0);
    check_output("s5_rst_perf", perf_cycles, 0);
    repeat (2) @(posedge clk);
    #1;
    check_output("s5_held_in_rst", busy, 0);
    rst = 1'b1;
    apply_stimulus(17, 34, 51, 68, 69);
    wait_cycle(1);
    start = 1'b0;
    check_output("s5_start_busy", busy, 1);
    check_output("s5_start_acc_clr", acc_clr, 1);
    check_output("s5_start_addr_A", rd_addr_A, 0);
    wait_cycle(71);
    check_output("s5_end_busy", busy, 0);

    // Everything queued must have been seen
    check_output("results_left", res_q.size(), 0);
    check_output("dones_left", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_tile_sequencer.md
# mm_tile_sequencer

Top-level sequencer for the systolic matrix-multiply kernel. On a `start` pulse it walks every output tile of an M×M product (N1 rows by N2 columns per tile), streams the M-deep K dimension from the A and B operand buffers, and flushes the array skew. It then presents each finished tile to the result path with a valid/ready handshake and pulses `done` after the last tile. It owns the only read ports into the operand buffers and the accumulator-clear strobe of the PE array.

## Interface
Parameters:
- `N1`, 4, PE array rows (A slice height); M must be a multiple of N1
- `N2`, 4, PE array columns (B slice width); M must be a multiple of N2
- `M`, 8, matrix dimension (K depth per tile)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a product; sampled only in IDLE
- `abort`  in  1  synchronous cancel; any state -> IDLE next cycle
- `stall`  in  1  operand buffers not ready; freezes streaming
- `res_ready`  in  1  result path accepts current tile
- `busy`  out  1  high in every state except IDLE
- `rd_en`  out  1  operand read strobe (A and B)
- `rd_addr_A`  out  clog2(M*M/N1)  A buffer address
- `rd_addr_B`  out  clog2(M*M/N2)  B buffer address
- `acc_clr`  out  1  clear PE accumulators, coincident with first K read of a tile
- `res_valid`  out  1  current tile result valid
- `res_tile_row`  out  max(clog2(M/N1),1)  tile row index ta
- `res_tile_col`  out  max(clog2(M/N2),1)  tile column index tb
- `done`  out  1  one-cycle pulse after the last tile is accepted
- `perf_cycles`  out  32  busy-cycle count (see Configuration)

## Operation
- Counters: `k` in 0..M-1; `ta` in 0..M/N1-1; `tb` in 0..M/N2-1. tb is the inner loop, ta the outer.
- Addresses are combinational from the counters: `rd_addr_A = ta*M + k`, `rd_addr_B = tb*M + k`. Products are computed at address width and never exceed (M*M/Nx)-1.
- States:
  - IDLE: all outputs 0. When `start` is high, clear k, ta, tb and go to STREAM.
  - STREAM: `rd_en = !stall`. `acc_clr = (k==0) && !stall`. k increments when `!stall`. When k==M-1 and `!stall`, go to DRAIN with the drain counter at 0. While stalled, addresses hold and `rd_en` and `acc_clr` are 0.
  - DRAIN: runs for exactly N1+N2 cycles (array skew N1+N2-1 plus one buffer read latency), then goes to RESULT. `stall` is ignored.
  - RESULT: `res_valid = 1`, with `res_tile_row = ta` and `res_tile_col = tb`, held stable until `res_valid && res_ready`.
    - On the handshake at the last tile (ta, tb both at maximum): go to DONE.
    - Otherwise: tb++ (on wrap to 0, ta++), k = 0, go to STREAM.
  - DONE: `done = 1` for one cycle, then IDLE. `start` is ignored in DONE.
- `abort` has priority over every transition. Next state is IDLE, counters clear, and `done` is not pulsed.
- `start` while busy is ignored.
- Reset mid-operation: all state and outputs return to IDLE values immediately (asynchronous), and no partial `done` is produced.

## Timing
- Reset values: `busy=0`, `rd_en=0`, `acc_clr=0`, `res_valid=0`, `done=0`, `res_tile_row=0`, `res_tile_col=0`, `rd_addr_A=0`, `rd_addr_B=0`, `perf_cycles=0`.
- Let `start` be seen in IDLE at cycle 0.
  - The first `rd_en`/`acc_clr` occurs at cycle 1.
  - With no stall and `res_ready` high, each tile takes M + N1 + N2 + 1 cycles (STREAM M, DRAIN N1+N2, RESULT 1).
- `done` occurs at cycle T*(M+N1+N2+1)+1, where T = (M/N1)*(M/N2).
- Each cycle of `stall` in STREAM adds one cycle. Each cycle of `res_ready` low in RESULT adds one cycle.
- All outputs are registered-state decodes. There are no combinational paths from inputs to outputs, except the `!stall` gating of `rd_en`/`acc_clr`.

## Configuration
- `MM_SEQ_PERF_CNT_EN`
  - Defined: `perf_cycles` counts every cycle with `busy` high, excluding DONE. It clears on an accepted `start`, holds its value in IDLE, and saturates at 32'hFFFF_FFFF.
  - Undefined: `perf_cycles` is tied to 0 and no counter logic is built.

## Test plan
- M=8, N1=N2=4, `start` at cycle 0, no stall, `res_ready=1` -> 4 tiles; `res_valid` at cycles 17, 34, 51, 68 with (ta,tb) = (0,0), (0,1), (1,0), (1,1); `done` at cycle 69; with macro defined, `perf_cycles` = 68.
- Tile (1,1) STREAM -> `rd_addr_A` sequence 8..15 and `rd_addr_B` sequence 8..15; `acc_clr` only with the first read (address 8).
- `stall` high for 3 cycles at k=5 of tile 0 -> addresses hold at 5, `rd_en` low for 3 cycles; the first `res_valid` moves from cycle 17 to cycle 20.
- `res_ready` low for 4 cycles at the tile-0 result -> `res_valid` and (0,0) held stable, no reads issued; tile 1 STREAM starts the cycle after acceptance.
- `abort` during tile-2 DRAIN -> IDLE next cycle, `busy=0`, no `done`; a new `start` restarts at tile (0,0) with address 0.
- `rst` asserted low mid-STREAM -> all outputs 0 immediately; after deassertion, `start` ignored until sampled in IDLE; `start` held high during DONE does not retrigger.
